// File: rtl/asyn_fifo_write_ctrl_if.sv
// Write-side bus of the async FIFO write controller.
// write_almost_full exists only with ASYN_FIFO_ALMOST_FULL_EN.
interface asyn_fifo_write_ctrl_if #(
  parameter int ADDR_WIDTH = 6
);
  logic                  write_ena;
  logic [ADDR_WIDTH:0]   read_ptr_gray;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [ADDR_WIDTH:0]   write_ptr_gray;
  logic                  write_full;
`ifdef ASYN_FIFO_ALMOST_FULL_EN
  logic                  write_almost_full;
`endif

  modport master (
    output write_ena,
    output read_ptr_gray,
    input  write_addr,
    input  write_ptr_gray,
`ifdef ASYN_FIFO_ALMOST_FULL_EN
    input  write_almost_full,
`endif
    input  write_full
  );

  modport slave (
    input  write_ena,
    input  read_ptr_gray,
    output write_addr,
    output write_ptr_gray,
`ifdef ASYN_FIFO_ALMOST_FULL_EN
    output write_almost_full,
`endif
    output write_full
  );
endinterface

// File: rtl/asyn_fifo_write_ctrl.sv
// Async FIFO write-domain pointer, Gray export and full flag.
// Optional almost-full flag under ASYN_FIFO_ALMOST_FULL_EN.
module asyn_fifo_write_ctrl #(
  parameter int ADDR_WIDTH      = 6,
  parameter int ALMOST_FULL_GAP = 4
) (
  input  logic write_clk,
  input  logic write_rst,
  asyn_fifo_write_ctrl_if.slave bus
);
  localparam int W     = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  if (ALMOST_FULL_GAP < 1 || ALMOST_FULL_GAP >= DEPTH) begin : g_chk
    $error("ALMOST_FULL_GAP out of range");
  end

  logic [W-1:0] wbin_q, wbin_d;
  logic [W-1:0] wgray_q, wgray_d;
  logic [W-1:0] rq1_q, rq2_q;
  logic         full_q, full_d;
  logic         accept;

  always_comb begin
    accept  = bus.write_ena & ~full_q;
    wbin_d  = wbin_q + W'(accept);
    wgray_d = (wbin_d >> 1) ^ wbin_d;
    // full: write Gray equals read Gray with the two MSBs flipped
    full_d  = (wgray_d == {~rq2_q[ADDR_WIDTH:ADDR_WIDTH-1],
                            rq2_q[ADDR_WIDTH-2:0]});
  end

  always_ff @(posedge write_clk) begin
    if (write_rst) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      rq1_q   <= '0;
      rq2_q   <= '0;
      full_q  <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      rq1_q   <= bus.read_ptr_gray;
      rq2_q   <= rq1_q;
      full_q  <= full_d;
    end
  end

  assign bus.write_addr     = wbin_q[ADDR_WIDTH-1:0];
  assign bus.write_ptr_gray = wgray_q;
  assign bus.write_full     = full_q;

`ifdef ASYN_FIFO_ALMOST_FULL_EN
  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [W-1:0] rbin, level;
  logic         afull_q, afull_d;

  always_comb begin
    rbin    = gray2bin(rq2_q);
    level   = wbin_d - rbin;
    afull_d = (level >= W'(DEPTH - ALMOST_FULL_GAP));
  end

  always_ff @(posedge write_clk) begin
    if (write_rst) begin
      afull_q <= 1'b0;
    end else begin
      afull_q <= afull_d;
    end
  end

  assign bus.write_almost_full = afull_q;
`endif
endmodule

// File: tb/tb_asyn_fifo_write_ctrl.sv
// Randomized self-checking bench for asyn_fifo_write_ctrl.
// Reference model works on binary occupancy counts.
module tb_asyn_fifo_write_ctrl;
  localparam int AW    = 6;
  localparam int DEPTH = 1 << AW;
  localparam int MOD   = 2 * DEPTH;
  localparam int GAP   = 4;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  asyn_fifo_write_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  asyn_fifo_write_ctrl #(
    .ADDR_WIDTH      (AW),
    .ALMOST_FULL_GAP (GAP)
  ) dut (
    .write_clk (clk),
    .write_rst (rst),
    .bus       (bus)
  );

  // model: write count, read count seen after 1 and 2 edges
  int w, s1, s2;
  bit fm, afm;
  int rd;

  function automatic logic [AW:0] to_gray(input int b);
    logic [AW:0] v;
    v = AW'(0) + (AW+1)'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit ena, input int rdp);
    int wn, lvl;
    rst               = r;
    bus.write_ena     = ena;
    bus.read_ptr_gray = to_gray(rdp);
    @(posedge clk);
    if (r) begin
      w = 0; s1 = 0; s2 = 0; fm = 0; afm = 0;
    end else begin
      wn  = (w + ((ena && !fm) ? 1 : 0)) % MOD;
      lvl = (wn - s2 + MOD) % MOD;
      fm  = (lvl == DEPTH);
      afm = (lvl >= DEPTH - GAP);
      w   = wn;
      s2  = s1;
      s1  = rdp;
    end
    #1;
    chk("addr", 32'(bus.write_addr), 32'(w % DEPTH));
    chk("gray", 32'(bus.write_ptr_gray), 32'(to_gray(w)));
    chk("full", 32'(bus.write_full), 32'(fm));
`ifdef ASYN_FIFO_ALMOST_FULL_EN
    chk("afull", 32'(bus.write_almost_full), 32'(afm));
`endif
  endtask

  initial begin
    logic [AW:0] pg;
    bit saw40, saw00;
    int n;
    w = 0; s1 = 0; s2 = 0; fm = 0; afm = 0; rd = 0;
    rst = 1'b1;
    bus.write_ena = 1'b0;
    bus.read_ptr_gray = '0;

    // reset with write requested
    step(1, 1, 0);
    step(1, 1, 0);
    chk("rst_gray", 32'(bus.write_ptr_gray), 32'h0);

    // fill
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 1, 0);
`ifdef ASYN_FIFO_ALMOST_FULL_EN
      if (i == DEPTH - GAP - 1)
        chk("af_rise", 32'(bus.write_almost_full), 32'h1);
`endif
    end
    chk("fill_full", 32'(bus.write_full), 32'h1);
    chk("fill_gray", 32'(bus.write_ptr_gray), 32'h60);
    chk("fill_addr", 32'(bus.write_addr), 32'h0);

    // overrun
    for (int i = 0; i < 10; i++) step(0, 1, 0);
    chk("ovr_gray", 32'(bus.write_ptr_gray), 32'h60);

    // release after third edge
    step(0, 0, 1);
    chk("rel_e1", 32'(bus.write_full), 32'h1);
    step(0, 0, 1);
    chk("rel_e2", 32'(bus.write_full), 32'h1);
    step(0, 0, 1);
    chk("rel_e3", 32'(bus.write_full), 32'h0);
    step(0, 1, 1);
    chk("rel_gray", 32'(bus.write_ptr_gray), 32'h61);

    // wrap with reader trailing by 4
    step(1, 0, 0);
    saw40 = 0; saw00 = 0; n = 0; rd = 0;
    for (int i = 0; i < 200; i++) begin
      pg = bus.write_ptr_gray;
      step(0, 1, rd);
      n++;
      if (n > 4) rd = (rd + 1) % MOD;
      chk("wrap_1bit", 32'($countones(pg ^ bus.write_ptr_gray)), 32'h1);
      if (bus.write_ptr_gray == 7'h40) saw40 = 1;
      if (saw40 && bus.write_ptr_gray == 7'h00) saw00 = 1;
    end
    chk("wrap_seen40", 32'(saw40), 32'h1);
    chk("wrap_seen00", 32'(saw00), 32'h1);

    // reset mid-run
    step(1, 0, 0);
    for (int i = 0; i < 30; i++) step(0, 1, 5);
    step(1, 1, 5);
    chk("mid_addr", 32'(bus.write_addr), 32'h0);
    chk("mid_sync", 32'(dut.rq2_q), 32'h0);
    step(0, 1, 0);
    chk("mid_resume", 32'(bus.write_ptr_gray), 32'h1);

    // random traffic
    step(1, 0, 0);
    rd = 0;
    for (int i = 0; i < 3000; i++) begin
      bit r, e;
      r = ($urandom_range(99) == 0);
      e = ($urandom_range(9) < 7);
      step(r, e, rd);
      if (r) rd = 0;
      else if (((w - rd + MOD) % MOD) > 0 && $urandom_range(9) < 4)
        rd = (rd + 1) % MOD;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
